// File: rtl/spi_adc_pkg.sv
// Shared definitions for the SPI ADC master.
// Holds the frame geometry (FRAME_BITS, RANGE_W) and the FSM state
// encoding used by spi_adc_master and visible on its state_dbg port.
package spi_adc_pkg;

  localparam int FRAME_BITS = 8;
  localparam int RANGE_W    = 2;

  // FSM state encoding.
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE     = 3'd0;
  localparam state_t ST_SHIFT_LO = 3'd1;
  localparam state_t ST_SHIFT_HI = 3'd2;
  localparam state_t ST_HOLD     = 3'd3;
  localparam state_t ST_GAP      = 3'd4;

endpackage

// File: rtl/spi_adc_tick.sv
// Half-period timer for the SPI ADC master.
// Counts clk cycles while run=1 and raises phase_end on the last cycle of
// each DIV-cycle phase. The count wraps at DIV-1 and is held at zero while
// run=0, so every phase (one per FSM state) starts from zero.
// Ports:
//   clk, rst_n - system clock, asynchronous active-low reset
//   run        - master is in a timed state (anything but IDLE)
//   phase_end  - high on the final cycle of the current phase
module spi_adc_tick #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic phase_end
);

  localparam logic [7:0] LAST = 8'(DIV - 1);

  logic [7:0] cnt;

  // Every state change happens on a phase_end (or leaving IDLE, where the
  // count is already zero), so clearing on phase_end restarts each state.
  assign phase_end = run && (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= 8'd0;
    end else if (!run || phase_end) begin
      cnt <= 8'd0;
    end else begin
      cnt <= cnt + 8'd1;
    end
  end

endmodule

// File: rtl/spi_adc_master.sv
// SPI master for a simple 8-bit ADC.
// Each accepted start runs one frame: cs low, 8 SCLK pulses (mode 0, MSB
// first) sending {6'b0, range_in} and collecting the ADC code, a DIV-cycle
// hold with cs low, then a DIV-cycle gap with cs high before returning to
// idle. The ADC reports the code converted under the range sent in the
// previous frame, so data_range tracks that earlier range.
// Handshake: start is sampled only while ready=1; a start seen with ready=1
// is accepted on that rising edge and ready drops on the same edge. There is
// no queuing, and start held high launches back-to-back frames.
// Ports:
//   clk, rst_n          - system clock, asynchronous active-low reset
//   start, range_in     - frame request and range code for that frame
//   ready               - idle, start will be accepted
//   done                - one-cycle pulse when a frame completes
//   data_out, data_range- last ADC code and the range it was converted under
//   sclk, cs, mosi, miso- SPI bus (sclk idle low, cs active low)
//   state_dbg           - current FSM state (spi_adc_pkg encoding)
// All outputs come straight from flops.
module spi_adc_master
  import spi_adc_pkg::*;
#(
  parameter int DIV = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [RANGE_W-1:0] range_in,
  output logic               ready,
  output logic               done,
  output logic [7:0]         data_out,
  output logic [RANGE_W-1:0] data_range,
  output logic               sclk,
  output logic               cs,
  output logic               mosi,
  input  logic               miso,
  output state_t             state_dbg
);

  state_t                  state;
  logic                    phase_end;
  logic [FRAME_BITS-1:0]   tx_word;
  logic [FRAME_BITS-2:0]   tx_rest;   // bits still to be sent after mosi
  logic [FRAME_BITS-1:0]   rx_sh;
  logic [2:0]              bit_cnt;
  logic [RANGE_W-1:0]      cur_range;
  logic [RANGE_W-1:0]      prev_range;

  assign tx_word   = {{(FRAME_BITS-RANGE_W){1'b0}}, range_in};
  assign state_dbg = state;

  spi_adc_tick #(.DIV(DIV)) u_tick (
    .clk       (clk),
    .rst_n     (rst_n),
    .run       (state != ST_IDLE),
    .phase_end (phase_end)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      ready      <= 1'b1;
      done       <= 1'b0;
      data_out   <= 8'h00;
      data_range <= '0;
      sclk       <= 1'b0;
      cs         <= 1'b1;
      mosi       <= 1'b0;
      tx_rest    <= '0;
      rx_sh      <= '0;
      bit_cnt    <= 3'd0;
      cur_range  <= '0;
      prev_range <= '0;   // ADC powers up in range 0
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state     <= ST_SHIFT_LO;
            ready     <= 1'b0;
            cs        <= 1'b0;
            sclk      <= 1'b0;
            mosi      <= tx_word[FRAME_BITS-1];
            tx_rest   <= tx_word[FRAME_BITS-2:0];
            cur_range <= range_in;
            bit_cnt   <= 3'd0;
          end
        end
        ST_SHIFT_LO: begin
          // miso has been stable for the whole low phase; sample it as sclk rises.
          if (phase_end) begin
            sclk  <= 1'b1;
            rx_sh <= {rx_sh[FRAME_BITS-2:0], miso};
            state <= ST_SHIFT_HI;
          end
        end
        ST_SHIFT_HI: begin
          if (phase_end) begin
            sclk <= 1'b0;
            if (bit_cnt != 3'(FRAME_BITS - 1)) begin
              bit_cnt <= bit_cnt + 3'd1;
              mosi    <= tx_rest[FRAME_BITS-2];
              tx_rest <= {tx_rest[FRAME_BITS-3:0], 1'b0};
              state   <= ST_SHIFT_LO;
            end else begin
              state <= ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (phase_end) begin
            cs    <= 1'b1;
            state <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (phase_end) begin
            data_out   <= rx_sh;
            data_range <= prev_range;
            prev_range <= cur_range;
            done       <= 1'b1;
            ready      <= 1'b1;
            state      <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
          ready <= 1'b1;
          cs    <= 1'b1;
          sclk  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_adc_master.sv
// Bench for spi_adc_master: one DIV=4 instance for the main frame tests and
// one DIV=1 instance for back-to-back timing, each with a behavioural ADC.
module tb_spi_adc_master;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DIV=4 instance ----------------
  logic       start4 = 1'b0;
  logic [1:0] range4 = 2'b00;
  logic       ready4, done4, sclk4, cs4, mosi4, miso4;
  logic [7:0] data_out4;
  logic [1:0] data_range4;
  logic [2:0] state4;

  spi_adc_master #(.DIV(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .range_in(range4),
    .ready(ready4), .done(done4), .data_out(data_out4), .data_range(data_range4),
    .sclk(sclk4), .cs(cs4), .mosi(mosi4), .miso(miso4), .state_dbg(state4)
  );

  // ADC model: code presented MSB first from cs fall, next bit on each sclk
  // fall; mosi sampled on sclk rise; range latched from last two bits at cs rise.
  logic [7:0] adc_code4 = 8'h00;
  logic [3:0] adc_bits4 = 4'd0;
  logic [7:0] adc_mosi4 = 8'h00;
  logic [1:0] adc_range4 = 2'b00;

  always @(negedge sclk4 or posedge cs4) begin
    if (cs4) adc_bits4 <= 4'd0;
    else     adc_bits4 <= adc_bits4 + 4'd1;
  end
  assign miso4 = (adc_bits4 < 4'd8) ? adc_code4[3'd7 - adc_bits4[2:0]] : 1'b0;

  always @(posedge sclk4 or posedge cs4) begin
    if (cs4) adc_range4 <= adc_mosi4[1:0];
    else     adc_mosi4  <= {adc_mosi4[6:0], mosi4};
  end

  // ---------------- DIV=1 instance ----------------
  logic       start1 = 1'b0;
  logic [1:0] range1 = 2'b00;
  logic       ready1, done1, sclk1, cs1, mosi1, miso1;
  logic [7:0] data_out1;
  logic [1:0] data_range1;
  logic [2:0] state1;

  spi_adc_master #(.DIV(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .range_in(range1),
    .ready(ready1), .done(done1), .data_out(data_out1), .data_range(data_range1),
    .sclk(sclk1), .cs(cs1), .mosi(mosi1), .miso(miso1), .state_dbg(state1)
  );

  logic [7:0] adc_code1 = 8'h00;
  logic [3:0] adc_bits1 = 4'd0;

  always @(negedge sclk1 or posedge cs1) begin
    if (cs1) adc_bits1 <= 4'd0;
    else     adc_bits1 <= adc_bits1 + 4'd1;
  end
  assign miso1 = (adc_bits1 < 4'd8) ? adc_code1[3'd7 - adc_bits1[2:0]] : 1'b0;

  // ---------------- monitors ----------------
  int   done_cnt4 = 0;
  int   mosi_bad4 = 0;
  logic mosi4_prev = 1'b0;

  always @(posedge clk) if (done4 === 1'b1) done_cnt4 <= done_cnt4 + 1;

  // mosi may only move on the edge that drops sclk (or at accept, sclk low).
  always @(negedge clk) begin
    if (mosi4 !== mosi4_prev && sclk4 === 1'b1) mosi_bad4 <= mosi_bad4 + 1;
    mosi4_prev <= mosi4;
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // One DIV=4 frame: start for one cycle, scramble range_in after accept,
  // wait for done and compare results and what the ADC model saw.
  task automatic run_frame4(input logic [7:0] code, input logic [1:0] rng,
                            input logic [7:0] exp_d, input logic [1:0] exp_r,
                            input logic [7:0] exp_m, input logic [1:0] exp_mr);
    int n;
    adc_code4 = code;
    range4    = rng;
    start4    = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    range4 = ~rng;
    chk("accept_ready_low", 32'(ready4), 32'd0);
    chk("accept_cs_low", 32'(cs4), 32'd0);
    n = 0;
    while (done4 !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("frame_latency", n, 32'd72);
    chk("data_out", 32'(data_out4), 32'(exp_d));
    chk("data_range", 32'(data_range4), 32'(exp_r));
    chk("adc_mosi_frame", 32'(adc_mosi4), 32'(exp_m));
    chk("adc_range", 32'(adc_range4), 32'(exp_mr));
    chk("ready_at_done", 32'(ready4), 32'd1);
    @(negedge clk);
    chk("done_one_cycle", 32'(done4), 32'd0);
  endtask

  typedef struct {
    logic [7:0] code;
    logic [1:0] rng;
    logic [7:0] exp_d;
    logic [1:0] exp_r;
    logic [7:0] exp_m;
    logic [1:0] exp_mr;
  } vec_t;

  vec_t vecs[4];

  // ---------------- test sequence ----------------
  initial begin
    int n;
    int cs_hi;
    int rdy_bad;
    int dc;

    vecs[0] = '{8'hA5, 2'b10, 8'hA5, 2'b00, 8'h02, 2'b10};
    vecs[1] = '{8'h3C, 2'b01, 8'h3C, 2'b10, 8'h01, 2'b01};
    vecs[2] = '{8'h81, 2'b11, 8'h81, 2'b01, 8'h03, 2'b11};
    vecs[3] = '{8'h5A, 2'b00, 8'h5A, 2'b11, 8'h00, 2'b00};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_cs", 32'(cs4), 32'd1);
    chk("rst_sclk", 32'(sclk4), 32'd0);
    chk("rst_mosi", 32'(mosi4), 32'd0);
    chk("rst_ready", 32'(ready4), 32'd1);
    chk("rst_done", 32'(done4), 32'd0);
    chk("rst_data_out", 32'(data_out4), 32'd0);
    chk("rst_data_range", 32'(data_range4), 32'd0);
    chk("rst_state", 32'(state4), 32'd0);
    chk("rst_cs_div1", 32'(cs1), 32'd1);
    rst_n = 1'b1;

    // Start right after reset release is accepted on the next edge.
    for (int i = 0; i < 4; i++)
      run_frame4(vecs[i].code, vecs[i].rng, vecs[i].exp_d, vecs[i].exp_r,
                 vecs[i].exp_m, vecs[i].exp_mr);

    // Start pulsed mid-frame is ignored.
    dc = done_cnt4;
    adc_code4 = 8'h77;
    range4    = 2'b10;
    start4    = 1'b1;
    @(negedge clk);
    start4  = 1'b0;
    chk("state_shift_lo", 32'(state4), 32'd1);
    n       = 0;
    rdy_bad = 0;
    repeat (9) begin
      @(negedge clk);
      n++;
      if (ready4 !== 1'b0) rdy_bad++;
    end
    start4 = 1'b1;
    @(negedge clk);
    n++;
    start4 = 1'b0;
    while (done4 !== 1'b1 && n < 400) begin
      if (ready4 !== 1'b0) rdy_bad++;
      @(negedge clk);
      n++;
    end
    chk("busy_start_latency", n, 32'd72);
    chk("busy_ready_low", rdy_bad, 32'd0);
    chk("busy_data_out", 32'(data_out4), 32'h77);
    repeat (100) @(negedge clk);
    chk("busy_single_done", done_cnt4 - dc, 32'd1);

    // Reset in the middle of a frame (sclk high at cycle 30).
    adc_code4 = 8'h99;
    range4    = 2'b11;
    start4    = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    repeat (30) @(negedge clk);
    chk("pre_rst_sclk_high", 32'(sclk4), 32'd1);
    dc = done_cnt4;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_cs", 32'(cs4), 32'd1);
    chk("mid_rst_sclk", 32'(sclk4), 32'd0);
    chk("mid_rst_ready", 32'(ready4), 32'd1);
    chk("mid_rst_data_out", 32'(data_out4), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (80) @(negedge clk);
    chk("mid_rst_no_done", done_cnt4 - dc, 32'd0);
    chk("mid_rst_data_hold", 32'(data_out4), 32'd0);
    run_frame4(8'h42, 2'b01, 8'h42, 2'b00, 8'h01, 2'b01);

    // DIV=1 with start held high: frames every 19 cycles.
    adc_code1 = 8'h00;
    range1    = 2'b00;
    start1    = 1'b1;
    n = 0;
    while (done1 !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("div1_first_done", n, 32'd19);
    chk("div1_data0", 32'(data_out1), 32'h00);
    adc_code1 = 8'hFF;
    n     = 0;
    cs_hi = 0;
    while (n < 100) begin
      @(negedge clk);
      n++;
      if (cs1 === 1'b1) cs_hi++;
      if (done1 === 1'b1) break;
    end
    start1 = 1'b0;
    chk("div1_period", n, 32'd19);
    chk("div1_cs_high", cs_hi, 32'd2);
    chk("div1_data1", 32'(data_out1), 32'hFF);
    chk("div1_range1", 32'(data_range1), 32'd0);
    repeat (5) @(negedge clk);
    chk("div1_idle_ready", 32'(ready1), 32'd1);
    chk("div1_idle_state", 32'(state1), 32'd0);

    chk("mosi_stable_sclk_high", mosi_bad4, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
